bus_txgen: RTL and testbench

Bus response frame generator: the transmit-side counterpart of the bus command parser. On a read command pulse (sensor ID) it fetches that sensor's 32-bit value, builds a 12-byte response frame with CRC-16/MODBUS, and streams it byte-by-byte to the bus byte transmitter. It holds one pending command while busy and flags any further commands as dropped.

---
 rtl/bus_txgen.sv | 187 ++++++++++++++++++
 tb/tb_bus_txgen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_txgen.sv
// bus_txgen: bus response frame generator.
// On a read command it fetches one sensor value, builds a 12-byte response
// frame (header, sensor ID, status, data, CRC-16/MODBUS) and streams it
// byte-by-byte to the byte transmitter. One extra command can wait in a
// single-entry pending buffer; commands beyond that are dropped.
module bus_txgen #(
  parameter logic [15:0] DEV_ID  = 16'h0001,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  ret_cmd,
  input  logic        ret_cmd_flg,
  output logic [7:0]  sen_rd_id,
  output logic        sen_rd_req,
  input  logic [31:0] sen_rd_data,
  input  logic        sen_rd_ack,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_done,
  output logic        busy,
  output logic        cmd_drop
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_ACK,
    S_SEND,
    S_WAIT_DONE
  } state_t;

  state_t        r_state;
  logic [7:0]    r_pend_id;
  logic          r_pend_vld;
  logic [31:0]   r_data;
  logic [7:0]    r_status;
  logic [3:0]    r_idx;
  logic [TW-1:0] r_timer;
  logic [15:0]   r_crc;
  logic [7:0]    r_sen_rd_id;
  logic          r_sen_rd_req;
  logic [7:0]    r_tx_data;
  logic          r_tx_start;
  logic          r_busy;
  logic          r_cmd_drop;

  logic [7:0]    w_byte;
  logic [15:0]   w_crc_next;
  logic [7:0]    w_new_id;

  // CRC-16/MODBUS, one byte per call (reflected poly 0xA001)
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    x = c ^ {8'h00, d};
    for (int unsigned i = 0; i < 8; i++) begin
      x = x[0] ? ((x >> 1) ^ 16'hA001) : (x >> 1);
    end
    return x;
  endfunction

  // Frame byte selected by the current byte index
  always_comb begin
    w_byte = r_crc[15:8];
    case (r_idx)
      4'd0:    w_byte = DEV_ID[15:8];
      4'd1:    w_byte = DEV_ID[7:0];
      4'd2:    w_byte = 8'h08;
      4'd3:    w_byte = 8'h00;
      4'd4:    w_byte = r_sen_rd_id;
      4'd5:    w_byte = r_status;
      4'd6:    w_byte = r_data[7:0];
      4'd7:    w_byte = r_data[15:8];
      4'd8:    w_byte = r_data[23:16];
      4'd9:    w_byte = r_data[31:24];
      4'd10:   w_byte = r_crc[7:0];
      default: w_byte = r_crc[15:8];
    endcase
  end

  // Next CRC value and the ID to serve when leaving IDLE (pending first)
  always_comb begin
    w_crc_next = crc16_byte(r_crc, w_byte);
    w_new_id   = r_pend_vld ? r_pend_id : ret_cmd;
  end

  // Frame FSM, pending buffer and all registered outputs
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state      <= S_IDLE;
      r_pend_id    <= '0;
      r_pend_vld   <= 1'b0;
      r_data       <= '0;
      r_status     <= '0;
      r_idx        <= '0;
      r_timer      <= '0;
      r_crc        <= '1;
      r_sen_rd_id  <= '0;
      r_sen_rd_req <= 1'b0;
      r_tx_data    <= '0;
      r_tx_start   <= 1'b0;
      r_busy       <= 1'b0;
      r_cmd_drop   <= 1'b0;
    end else begin
      r_sen_rd_req <= 1'b0;
      r_tx_start   <= 1'b0;
      r_cmd_drop   <= 1'b0;

      if (r_busy && ret_cmd_flg) begin
        if (!r_pend_vld) begin
          r_pend_id  <= ret_cmd;
          r_pend_vld <= 1'b1;
        end else begin
          r_cmd_drop <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (r_pend_vld || ret_cmd_flg) begin
            r_sen_rd_id  <= w_new_id;
            r_sen_rd_req <= 1'b1;
            r_busy       <= 1'b1;
            r_crc        <= '1;
            r_idx        <= '0;
            r_state      <= S_REQ;
            // A fresh command arriving while the pending one is consumed
            // refills the buffer instead of being lost.
            if (r_pend_vld) begin
              r_pend_vld <= ret_cmd_flg;
              r_pend_id  <= ret_cmd;
            end
          end
        end
        S_REQ: begin
          r_timer <= '0;
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (sen_rd_ack) begin
            r_data   <= sen_rd_data;
            r_status <= 8'h03;
            r_state  <= S_SEND;
          end else if (r_timer == TMO_LAST) begin
            r_data   <= '1;
            r_status <= 8'hEE;
            r_state  <= S_SEND;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_SEND: begin
          r_tx_start <= 1'b1;
          r_tx_data  <= w_byte;
          if (r_idx <= 4'd9) begin
            r_crc <= w_crc_next;
          end
          r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (tx_done) begin
            if (r_idx == 4'd11) begin
              r_idx   <= '0;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_state <= S_SEND;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sen_rd_id  = r_sen_rd_id;
  assign sen_rd_req = r_sen_rd_req;
  assign tx_data    = r_tx_data;
  assign tx_start   = r_tx_start;
  assign busy       = r_busy;
  assign cmd_drop   = r_cmd_drop;

endmodule

// File: tb/tb_bus_txgen.sv
// tb_bus_txgen: scoreboard bench for bus_txgen.
// Stimulus pushes expected frame bytes / sensor IDs into queues; a monitor
// pops and compares whenever the DUT issues tx_start or sen_rd_req.
module tb_bus_txgen;

  localparam int unsigned TO = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [7:0]  ret_cmd;
  logic        ret_cmd_flg;
  logic [7:0]  sen_rd_id;
  logic        sen_rd_req;
  logic [31:0] sen_rd_data;
  logic        sen_rd_ack;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        busy;
  logic        cmd_drop;

  bus_txgen #(.DEV_ID(16'h0001), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .ret_cmd(ret_cmd), .ret_cmd_flg(ret_cmd_flg),
    .sen_rd_id(sen_rd_id), .sen_rd_req(sen_rd_req),
    .sen_rd_data(sen_rd_data), .sen_rd_ack(sen_rd_ack),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .busy(busy), .cmd_drop(cmd_drop)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { logic [7:0] b; int idx; int lat; } exp_t;
  typedef struct { logic [7:0] id; bit chk_gap; } id_t;
  exp_t exp_q[$];
  id_t  id_q[$];

  // Bit-serial CRC-16/MODBUS reference
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
      else             c = c >> 1;
    end
    return c;
  endfunction

  task automatic push_frame(input logic [7:0] id, input logic [7:0] st,
                            input logic [31:0] dat, input int lat0, input bit gap);
    logic [7:0]  f [12];
    logic [15:0] c;
    exp_t        e;
    id_t         ie;
    f[0] = 8'h00; f[1] = 8'h01; f[2] = 8'h08; f[3] = 8'h00;
    f[4] = id;    f[5] = st;
    f[6] = dat[7:0]; f[7] = dat[15:8]; f[8] = dat[23:16]; f[9] = dat[31:24];
    c = 16'hFFFF;
    for (int i = 0; i < 10; i++) c = crc_model(c, f[i]);
    f[10] = c[7:0]; f[11] = c[15:8];
    for (int i = 0; i < 12; i++) begin
      e.b = f[i]; e.idx = i; e.lat = (i == 0) ? lat0 : -1;
      exp_q.push_back(e);
    end
    ie.id = id; ie.chk_gap = gap;
    id_q.push_back(ie);
  endtask

  // Responder state: byte transmitter and sensor
  bit          tx_rand  = 0;
  int          tx_fixed = 2;
  int          tx_cnt   = -1;
  bit          tx_out   = 0;
  logic [7:0]  tx_hold  = '0;
  int          done_cyc = 0;
  int          ack_off  = 3;
  int          ack_cnt  = -1;
  logic [31:0] ack_data = '0;

  // Byte transmitter and sensor models
  always @(negedge sys_clk) begin
    tx_done    = 1'b0;
    sen_rd_ack = 1'b0;
    if (sys_rst) begin
      tx_cnt  = -1;
      tx_out  = 0;
      ack_cnt = -1;
    end else begin
      if (tx_cnt == 0) begin
        tx_done  = 1'b1;
        done_cyc = cyc;
        tx_cnt   = -1;
        tx_out   = 0;
        check("tx_data_stable", tx_data, tx_hold);
      end else if (tx_cnt > 0) begin
        tx_cnt--;
      end
      if (tx_start) begin
        check("single_tx_start", tx_out, 1'b0);
        tx_out  = 1;
        tx_hold = tx_data;
        tx_cnt  = tx_rand ? int'($urandom_range(50, 0)) : tx_fixed;
      end
      if (ack_cnt == 0) begin
        sen_rd_ack  = 1'b1;
        sen_rd_data = ack_data;
        ack_cnt     = -1;
      end else if (ack_cnt > 0) begin
        ack_cnt--;
      end
      if (sen_rd_req && ack_off > 0) ack_cnt = ack_off - 1;
    end
  end

  // Monitor: scoreboard pop/compare on every DUT request or byte start
  int req_cyc  = 0;
  int drop_cnt = 0;
  int n_starts = 0;
  always @(negedge sys_clk) begin
    exp_t e;
    id_t  ie;
    if (!sys_rst) begin
      if (sen_rd_req) begin
        req_cyc = cyc;
        if (id_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_sen_rd_req: got id %h, expected none", sen_rd_id);
        end else begin
          ie = id_q.pop_front();
          check("sen_rd_id", sen_rd_id, ie.id);
          if (ie.chk_gap) check("pending_req_gap", cyc - done_cyc, 2);
        end
      end
      if (tx_start) begin
        n_starts++;
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_tx_start: got byte %h, expected none", tx_data);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("tx_byte%0d", e.idx), tx_data, e.b);
          if (e.idx == 0 && e.lat >= 0) check("req_to_first_start", cyc - req_cyc, e.lat);
          if (e.idx > 0) check("done_to_next_start", cyc - done_cyc, 2);
        end
      end
      if (cmd_drop) drop_cnt++;
    end
  end

  task automatic send_cmd(input logic [7:0] id, input bit chk_busy);
    @(negedge sys_clk);
    ret_cmd     = id;
    ret_cmd_flg = 1'b1;
    @(negedge sys_clk);
    ret_cmd_flg = 1'b0;
    if (chk_busy) check("busy_after_cmd", busy, 1'b1);
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || id_q.size() != 0 || busy) && k < budget) begin
      @(negedge sys_clk);
      k++;
    end
    check({nm, "_completes"}, (k < budget), 1'b1);
    repeat (10) @(negedge sys_clk);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_sen_rd_id"},  sen_rd_id,  8'h00);
    check({nm, "_sen_rd_req"}, sen_rd_req, 1'b0);
    check({nm, "_tx_data"},    tx_data,    8'h00);
    check({nm, "_tx_start"},   tx_start,   1'b0);
    check({nm, "_busy"},       busy,       1'b0);
    check({nm, "_cmd_drop"},   cmd_drop,   1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c;
    logic [7:0]  s [9];
    int          d0, s0, k, act;

    sys_rst = 1'b1; ret_cmd = '0; ret_cmd_flg = 1'b0;
    sen_rd_data = '0; sen_rd_ack = 1'b0; tx_done = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_reset_outputs("reset");
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // CRC reference against the standard check string "123456789"
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    c = 16'hFFFF;
    for (int i = 0; i < 9; i++) c = crc_model(c, s[i]);
    check("crc_model_selftest", c, 16'h4B37);

    // Read OK: ack 3 cycles after request -> first byte 5 cycles after request
    ack_off = 3; ack_data = 32'h1234_5678;
    push_frame(8'h05, 8'h03, 32'h1234_5678, 5, 0);
    send_cmd(8'h05, 1);
    wait_done("read_ok", 400);

    // Timeout: no ack -> first byte TIMEOUT+2 cycles after request
    ack_off = 0;
    push_frame(8'h07, 8'hEE, 32'hFFFF_FFFF, TO + 2, 0);
    send_cmd(8'h07, 1);
    wait_done("timeout", 400);

    // Ack on the timeout cycle wins
    ack_off = TO; ack_data = 32'hA5A5_A5A5;
    push_frame(8'h09, 8'h03, 32'hA5A5_A5A5, TO + 2, 0);
    send_cmd(8'h09, 1);
    wait_done("ack_at_timeout", 400);

    // Pending and drop: 01 served, 02 buffered, 03 dropped
    ack_off = 3; ack_data = 32'hCAFE_F00D;
    d0 = drop_cnt;
    push_frame(8'h01, 8'h03, 32'hCAFE_F00D, 5, 0);
    push_frame(8'h02, 8'h03, 32'hCAFE_F00D, 5, 1);
    send_cmd(8'h01, 1);
    repeat (8) @(negedge sys_clk);
    send_cmd(8'h02, 0);
    repeat (8) @(negedge sys_clk);
    send_cmd(8'h03, 0);
    wait_done("pending", 600);
    check("cmd_drop_pulses", drop_cnt - d0, 1);

    // Slow transmitter with random tx_done delays
    tx_rand = 1;
    s0 = n_starts;
    push_frame(8'h21, 8'h03, 32'hCAFE_F00D, 5, 0);
    send_cmd(8'h21, 1);
    wait_done("slow_tx", 1500);
    check("slow_tx_byte_count", n_starts - s0, 12);
    tx_rand = 0;

    // Reset at byte 6 while a command is pending
    ack_data = 32'h55AA_1234;
    push_frame(8'h30, 8'h03, 32'h55AA_1234, 5, 0);
    send_cmd(8'h30, 1);
    repeat (4) @(negedge sys_clk);
    send_cmd(8'h31, 0);
    k = 0;
    for (int i = 0; i < 400 && k < 7; i++) begin
      @(negedge sys_clk);
      if (tx_start) k++;
    end
    check("reached_byte6", k, 7);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check_reset_outputs("midframe_reset");
    exp_q.delete();
    id_q.delete();
    @(negedge sys_clk);
    sys_rst = 1'b0;
    act = 0;
    repeat (40) begin
      @(negedge sys_clk);
      if (tx_start || sen_rd_req) act++;
    end
    check("quiet_after_reset", act, 0);

    // Recovery after reset
    ack_data = 32'h0BAD_C0DE;
    push_frame(8'h40, 8'h03, 32'h0BAD_C0DE, 5, 0);
    send_cmd(8'h40, 1);
    wait_done("after_reset", 400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
